// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter in front of one variable-latency memory.
// Requester 0 is instruction fetch (read-only), requester 1 is the load/store
// data port. Each access goes IDLE -> BUSY -> DONE; a timeout aborts accesses
// the memory never completes.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_if_req,
  input  logic [ADDR_W-1:0]   i_if_addr,
  output logic                o_if_ack,
  output logic [DATA_W-1:0]   o_if_rdata,
  input  logic                i_d_req,
  input  logic                i_d_we,
  input  logic [ADDR_W-1:0]   i_d_addr,
  input  logic [DATA_W-1:0]   i_d_wdata,
  input  logic [DATA_W/8-1:0] i_d_wstrb,
  output logic                o_d_ack,
  output logic [DATA_W-1:0]   o_d_rdata,
  output logic                o_err,
  output logic                o_stall,
  output logic                o_mem_en,
  output logic                o_mem_we,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic [DATA_W-1:0]   o_mem_wdata,
  output logic [DATA_W/8-1:0] o_mem_wstrb,
  input  logic                i_mem_ready,
  input  logic [DATA_W-1:0]   i_mem_rdata
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e              state_q,      state_d;
  logic                last_grant_q, last_grant_d;
  logic                gnt_q,        gnt_d;        // 0 = fetch, 1 = data
  logic [ADDR_W-1:0]   addr_q,       addr_d;
  logic                we_q,         we_d;
  logic [DATA_W-1:0]   wdata_q,      wdata_d;
  logic [STRB_W-1:0]   wstrb_q,      wstrb_d;
  logic [CNT_W-1:0]    cnt_q,        cnt_d;
  logic                if_ack_q,     if_ack_d;
  logic                d_ack_q,      d_ack_d;
  logic                err_q,        err_d;
  logic [DATA_W-1:0]   if_rdata_q,   if_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q,    d_rdata_d;
  logic                mem_en_q,     mem_en_d;
  logic                mem_we_q,     mem_we_d;

  logic                pick_s;       // port chosen in IDLE
  logic                finish_s;     // BUSY access ends this cycle
  logic [DATA_W-1:0]   result_s;     // value written to the granted rdata

  // Next-state, grant selection, latching and completion logic.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_d        = gnt_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    cnt_d        = cnt_q;
    if_ack_d     = 1'b0;
    d_ack_d      = 1'b0;
    err_d        = 1'b0;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    pick_s       = 1'b0;
    finish_s     = 1'b0;
    result_s     = {DATA_W{1'b0}};

    case (state_q)
      ST_IDLE: begin
        if (i_if_req || i_d_req) begin
          // Under contention the port that did not win last time goes first.
          if (i_if_req && i_d_req) begin
            pick_s = ~last_grant_q;
          end else if (i_d_req) begin
            pick_s = 1'b1;
          end else begin
            pick_s = 1'b0;
          end
          gnt_d        = pick_s;
          last_grant_d = pick_s;
          cnt_d        = {CNT_W{1'b0}};
          state_d      = ST_BUSY;
          if (pick_s) begin
            addr_d  = i_d_addr;
            we_d    = i_d_we;
            wdata_d = i_d_wdata;
            wstrb_d = i_d_wstrb;
          end else begin
            addr_d  = i_if_addr;
            we_d    = 1'b0;
            wdata_d = {DATA_W{1'b0}};
            wstrb_d = {STRB_W{1'b0}};
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_BUSY: begin
        if (i_mem_ready) begin
          // Writes return zero so a stale read value never leaks to the core.
          finish_s = 1'b1;
          result_s = we_q ? {DATA_W{1'b0}} : i_mem_rdata;
          err_d    = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          finish_s = 1'b1;
          result_s = {DATA_W{1'b0}};
          err_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end

        if (finish_s) begin
          state_d  = ST_DONE;
          if_ack_d = ~gnt_q;
          d_ack_d  = gnt_q;
          if (gnt_q) begin
            d_rdata_d = result_s;
          end else begin
            if_rdata_d = result_s;
          end
        end else begin
          state_d = ST_BUSY;
        end
      end

      ST_DONE: begin
        // Requests are not looked at here, so a held req is not re-serviced.
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    mem_en_d = (state_d == ST_BUSY);
    mem_we_d = mem_en_d & we_d;
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      gnt_q        <= 1'b0;
      addr_q       <= {ADDR_W{1'b0}};
      we_q         <= 1'b0;
      wdata_q      <= {DATA_W{1'b0}};
      wstrb_q      <= {STRB_W{1'b0}};
      cnt_q        <= {CNT_W{1'b0}};
      if_ack_q     <= 1'b0;
      d_ack_q      <= 1'b0;
      err_q        <= 1'b0;
      if_rdata_q   <= {DATA_W{1'b0}};
      d_rdata_q    <= {DATA_W{1'b0}};
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_q        <= gnt_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      cnt_q        <= cnt_d;
      if_ack_q     <= if_ack_d;
      d_ack_q      <= d_ack_d;
      err_q        <= err_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
    end
  end

  assign o_if_ack    = if_ack_q;
  assign o_if_rdata  = if_rdata_q;
  assign o_d_ack     = d_ack_q;
  assign o_d_rdata   = d_rdata_q;
  assign o_err       = err_q;
  assign o_mem_en    = mem_en_q;
  assign o_mem_we    = mem_we_q;
  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = wdata_q;
  assign o_mem_wstrb = wstrb_q;

  // Stall drops in the ack cycle so the core advances exactly once per access.
  assign o_stall = (i_if_req & ~if_ack_q) | (i_d_req & ~d_ack_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (TIMEOUT overridden to 4).
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_if_req;
  logic [AW-1:0] i_if_addr;
  logic          o_if_ack;
  logic [DW-1:0] o_if_rdata;
  logic          i_d_req;
  logic          i_d_we;
  logic [AW-1:0] i_d_addr;
  logic [DW-1:0] i_d_wdata;
  logic [SW-1:0] i_d_wstrb;
  logic          o_d_ack;
  logic [DW-1:0] o_d_rdata;
  logic          o_err;
  logic          o_stall;
  logic          o_mem_en;
  logic          o_mem_we;
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] o_mem_wdata;
  logic [SW-1:0] o_mem_wstrb;
  logic          i_mem_ready;
  logic [DW-1:0] i_mem_rdata;

  int n_checks = 0;
  int n_errors = 0;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr),
    .o_if_ack(o_if_ack), .o_if_rdata(o_if_rdata),
    .i_d_req(i_d_req), .i_d_we(i_d_we), .i_d_addr(i_d_addr),
    .i_d_wdata(i_d_wdata), .i_d_wstrb(i_d_wstrb),
    .o_d_ack(o_d_ack), .o_d_rdata(o_d_rdata),
    .o_err(o_err), .o_stall(o_stall),
    .o_mem_en(o_mem_en), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_wstrb(o_mem_wstrb),
    .i_mem_ready(i_mem_ready), .i_mem_rdata(i_mem_rdata)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Directed stimulus and checks.
  initial begin
    int en_cnt;
    int ack_cnt;
    logic drop_next;

    rst = 1'b1; i_if_req = 1'b0; i_if_addr = 32'h0;
    i_d_req = 1'b0; i_d_we = 1'b0; i_d_addr = 32'h0;
    i_d_wdata = 32'h0; i_d_wstrb = 4'h0;
    i_mem_ready = 1'b0; i_mem_rdata = 32'h0;

    // Reset state
    repeat (2) cyc();
    rst = 1'b0;
    #1;
    check_val("rst_if_ack",  o_if_ack, 1'b0);
    check_val("rst_d_ack",   o_d_ack, 1'b0);
    check_val("rst_err",     o_err, 1'b0);
    check_val("rst_mem_en",  o_mem_en, 1'b0);
    check_val("rst_mem_we",  o_mem_we, 1'b0);
    check_val("rst_addr",    o_mem_addr, 32'h0);
    check_val("rst_if_rd",   o_if_rdata, 32'h0);
    check_val("rst_d_rd",    o_d_rdata, 32'h0);
    check_val("rst_stall",   o_stall, 1'b0);

    // Fetch-only read, ready on the first BUSY cycle
    i_if_req = 1'b1; i_if_addr = 32'h100;
    #1;
    check_val("t1_stall0", o_stall, 1'b1);
    check_val("t1_en0",    o_mem_en, 1'b0);
    cyc();
    i_mem_ready = 1'b1; i_mem_rdata = 32'hDEADBEEF;
    #1;
    check_val("t1_en1",    o_mem_en, 1'b1);
    check_val("t1_addr",   o_mem_addr, 32'h100);
    check_val("t1_we",     o_mem_we, 1'b0);
    check_val("t1_stall1", o_stall, 1'b1);
    check_val("t1_noack",  o_if_ack, 1'b0);
    cyc();
    i_mem_ready = 1'b0; i_mem_rdata = 32'h0;
    #1;
    check_val("t1_ack",    o_if_ack, 1'b1);
    check_val("t1_rdata",  o_if_rdata, 32'hDEADBEEF);
    check_val("t1_err",    o_err, 1'b0);
    check_val("t1_en2",    o_mem_en, 1'b0);
    check_val("t1_stall2", o_stall, 1'b0);
    check_val("t1_d_ack",  o_d_ack, 1'b0);
    i_if_req = 1'b0;
    cyc();
    #1;
    check_val("t1_ack_end", o_if_ack, 1'b0);
    check_val("t1_hold",    o_if_rdata, 32'hDEADBEEF);

    // Data write, ready after three wait cycles (last BUSY cycle at count TIMEOUT-1)
    i_d_req = 1'b1; i_d_we = 1'b1; i_d_addr = 32'h40;
    i_d_wdata = 32'h12345678; i_d_wstrb = 4'h3; i_mem_rdata = 32'hFFFFFFFF;
    for (int k = 0; k < 4; k++) begin
      cyc();
      if (k == 3) i_mem_ready = 1'b1;
      #1;
      check_val("t2_en",    o_mem_en, 1'b1);
      check_val("t2_we",    o_mem_we, 1'b1);
      check_val("t2_addr",  o_mem_addr, 32'h40);
      check_val("t2_wdata", o_mem_wdata, 32'h12345678);
      check_val("t2_wstrb", o_mem_wstrb, 4'h3);
      check_val("t2_noack", o_d_ack, 1'b0);
    end
    cyc();
    i_mem_ready = 1'b0;
    #1;
    check_val("t2_ack",     o_d_ack, 1'b1);
    check_val("t2_rdata",   o_d_rdata, 32'h0);
    check_val("t2_err",     o_err, 1'b0);
    check_val("t2_if_ack",  o_if_ack, 1'b0);
    check_val("t2_if_keep", o_if_rdata, 32'hDEADBEEF);
    check_val("t2_en_off",  o_mem_en, 1'b0);
    i_d_req = 1'b0; i_d_we = 1'b0;
    cyc();
    #1;
    check_val("t2_ack_end", o_d_ack, 1'b0);

    // Both requesters held, ready always high: alternating grants, fetch first
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    i_if_req = 1'b1; i_if_addr = 32'h200;
    i_d_req = 1'b1; i_d_addr = 32'h300; i_d_we = 1'b0;
    i_mem_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cyc();
      i_mem_rdata = 32'hC0DE0000 + 32'(i);
      #1;
      check_val("t3_en",     o_mem_en, ((i % 3) == 0) ? 1'b1 : 1'b0);
      check_val("t3_if_ack", o_if_ack, (i == 1 || i == 7) ? 1'b1 : 1'b0);
      check_val("t3_d_ack",  o_d_ack, (i == 4 || i == 10) ? 1'b1 : 1'b0);
      if ((i % 3) == 0)
        check_val("t3_addr", o_mem_addr, (i == 0 || i == 6) ? 32'h200 : 32'h300);
      if (i == 1 || i == 7)
        check_val("t3_if_rd", o_if_rdata, 32'hC0DE0000 + 32'(i - 1));
      if (i == 4 || i == 10)
        check_val("t3_d_rd", o_d_rdata, 32'hC0DE0000 + 32'(i - 1));
    end
    i_if_req = 1'b0; i_d_req = 1'b0; i_mem_ready = 1'b0;
    cyc();

    // Requester keeps req high through its DONE cycle: one access, one ack
    i_d_req = 1'b1; i_d_we = 1'b0; i_d_addr = 32'h44;
    i_mem_ready = 1'b1; i_mem_rdata = 32'h4444AAAA;
    en_cnt = 0; ack_cnt = 0; drop_next = 1'b0;
    for (int i = 0; i < 7; i++) begin
      cyc();
      if (drop_next) i_d_req = 1'b0;
      #1;
      if (o_mem_en) en_cnt++;
      if (o_d_ack) begin
        ack_cnt++;
        drop_next = 1'b1;
        check_val("t4_rdata", o_d_rdata, 32'h4444AAAA);
      end
    end
    check_val("t4_accesses", en_cnt, 1);
    check_val("t4_acks",     ack_cnt, 1);
    i_d_req = 1'b0; i_mem_ready = 1'b0;
    cyc();

    // Timeout on fetch (ready never comes), then pending data serviced
    i_if_req = 1'b1; i_if_addr = 32'h180;
    i_d_req = 1'b1; i_d_addr = 32'h80; i_d_we = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      #1;
      check_val("t5_en",    o_mem_en, 1'b1);
      check_val("t5_addr",  o_mem_addr, 32'h180);
      check_val("t5_noack", o_if_ack, 1'b0);
    end
    cyc();
    #1;
    check_val("t5_ack",   o_if_ack, 1'b1);
    check_val("t5_err",   o_err, 1'b1);
    check_val("t5_rdata", o_if_rdata, 32'h0);
    check_val("t5_en0",   o_mem_en, 1'b0);
    check_val("t5_d_ack", o_d_ack, 1'b0);
    check_val("t5_stall", o_stall, 1'b1);
    i_if_req = 1'b0;
    cyc();
    #1;
    check_val("t5_idle_en", o_mem_en, 1'b0);
    check_val("t5_err_clr", o_err, 1'b0);
    cyc();
    i_mem_ready = 1'b1; i_mem_rdata = 32'h0BADF00D;
    #1;
    check_val("t5_d_en",   o_mem_en, 1'b1);
    check_val("t5_d_addr", o_mem_addr, 32'h80);
    cyc();
    i_mem_ready = 1'b0;
    #1;
    check_val("t5_d_ack2", o_d_ack, 1'b1);
    check_val("t5_d_err",  o_err, 1'b0);
    check_val("t5_d_rd",   o_d_rdata, 32'h0BADF00D);
    i_d_req = 1'b0;
    cyc();

    // Reset during a fetch BUSY; round-robin restarts from its reset value
    i_if_req = 1'b1; i_if_addr = 32'h500;
    cyc();
    #1;
    check_val("t6_busy", o_mem_en, 1'b1);
    rst = 1'b1;
    cyc();
    #1;
    check_val("t6_en",     o_mem_en, 1'b0);
    check_val("t6_if_ack", o_if_ack, 1'b0);
    check_val("t6_d_ack",  o_d_ack, 1'b0);
    check_val("t6_err",    o_err, 1'b0);
    check_val("t6_if_rd",  o_if_rdata, 32'h0);
    rst = 1'b0;
    i_d_req = 1'b1; i_d_addr = 32'h600; i_d_we = 1'b0;
    cyc();
    #1;
    check_val("t6_grant_en",   o_mem_en, 1'b1);
    check_val("t6_grant_addr", o_mem_addr, 32'h500);
    i_mem_ready = 1'b1; i_mem_rdata = 32'h00000077;
    cyc();
    i_mem_ready = 1'b0;
    #1;
    check_val("t6_ack",   o_if_ack, 1'b1);
    check_val("t6_rdata", o_if_rdata, 32'h00000077);
    i_if_req = 1'b0; i_d_req = 1'b0;
    repeat (3) cyc();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
